// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-host memory arbiter: ownership tags and FSM states.
package Types;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_t;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction host and a data host onto one memory agent,
// alternating on ties and inserting an idle bubble after every transaction.
module mem_arbiter
  import Types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_address,
  input  logic                i_read,
  output logic [DATA_W-1:0]   i_readdata,
  output logic                i_waitrequest,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W-1:0]   d_writedata,
  input  logic [DATA_W/8-1:0] d_byteenable,
  output logic [DATA_W-1:0]   d_readdata,
  output logic                d_waitrequest,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest,
  output logic [CNT_W-1:0]    conflict_count
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  owner_t           r_last_owner;
  owner_t           w_last_owner_nxt;
  logic [CNT_W-1:0] r_conflict_count;
  logic             w_conflict;
  logic             w_i_req;
  logic             w_d_req;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // State, fairness flag and tie counter; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= ARB_IDLE;
      r_last_owner     <= OWNER_INSTR;
      r_conflict_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      if (w_conflict) begin
        r_conflict_count <= r_conflict_count + CNT_W'(1);
      end
    end
  end

  // Next-state decode and combinational forwarding of the owning host.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_conflict       = 1'b0;
    m_address        = '0;
    m_read           = 1'b0;
    m_write          = 1'b0;
    m_writedata      = '0;
    m_byteenable     = '0;
    i_waitrequest    = 1'b1;
    d_waitrequest    = 1'b1;

    case (r_state)
      ARB_IDLE: begin
        if (w_i_req && w_d_req) begin
          w_conflict = 1'b1;
          if (r_last_owner == OWNER_INSTR) begin
            w_state_nxt      = ARB_OWN_D;
            w_last_owner_nxt = OWNER_DATA;
          end else begin
            w_state_nxt      = ARB_OWN_I;
            w_last_owner_nxt = OWNER_INSTR;
          end
        end else if (w_i_req) begin
          w_state_nxt      = ARB_OWN_I;
          w_last_owner_nxt = OWNER_INSTR;
        end else if (w_d_req) begin
          w_state_nxt      = ARB_OWN_D;
          w_last_owner_nxt = OWNER_DATA;
        end
      end

      ARB_OWN_I: begin
        m_address     = i_address;
        m_read        = i_read;
        m_byteenable  = {BE_W{1'b1}};
        i_waitrequest = m_waitrequest;
        if (!w_i_req || !m_waitrequest) begin
          w_state_nxt = ARB_IDLE;
        end
      end

      ARB_OWN_D: begin
        // A simultaneous read+write is treated as a write.
        m_address     = d_address;
        m_write       = d_write;
        m_read        = d_read & ~d_write;
        m_writedata   = d_writedata;
        m_byteenable  = d_byteenable;
        d_waitrequest = m_waitrequest;
        if (!w_d_req || !m_waitrequest) begin
          w_state_nxt = ARB_IDLE;
        end
      end

      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  assign i_readdata     = m_readdata;
  assign d_readdata     = m_readdata;
  assign conflict_count = r_conflict_count;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all three ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width; byteenable width is DATA_W/8.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as the codebase does: clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 i_address  input  ADDR_W  instruction-host read address.
REQ-007 i_read  input  1  instruction-host read request.
REQ-008 i_readdata  output  DATA_W  read data to the instruction host.
REQ-009 i_waitrequest  output  1  stall to the instruction host.
REQ-010 d_address  input  ADDR_W  data-host address.
REQ-011 d_read, d_write  input  1 each  data-host read and write requests.
REQ-012 d_writedata  input  DATA_W  data-host write data.
REQ-013 d_byteenable  input  DATA_W/8  data-host byte lanes.
REQ-014 d_readdata  output  DATA_W  read data to the data host.
REQ-015 d_waitrequest  output  1  stall to the data host.
REQ-016 m_address, m_read, m_write, m_writedata, m_byteenable  output  (as host side)  request to the shared memory agent.
REQ-017 m_readdata  input  DATA_W  agent read data.
REQ-018 m_waitrequest  input  1  agent stall.
REQ-019 conflict_count  output  32  number of arbitration cycles in which both hosts requested.

Function
REQ-020 SHALL implement a state machine with three states: IDLE, OWN_I and OWN_D.
REQ-021 In IDLE, the m_* strobes SHALL be 0 and m_address, m_writedata and m_byteenable SHALL be 0.
REQ-022 IDLE transitions:
- If only i_read is high, the next state SHALL be OWN_I.
- If only d_read or d_write is high, the next state SHALL be OWN_D.
- If neither host requests, the FSM SHALL stay in IDLE.
REQ-023 If both hosts request in IDLE, the arbiter SHALL grant the host that was not last_owner; last_owner SHALL update on every grant.
REQ-024 In OWN_x, the arbiter SHALL forward host x's address, strobes, writedata and byteenable to m_* combinationally; for the instruction host, byteenable SHALL be all ones.
REQ-025 OWN_x SHALL return to IDLE on the first cycle in which m_waitrequest=0; there SHALL be no back-to-back grant, so a one-cycle bubble follows every transaction.
REQ-026 x_waitrequest SHALL be 0 only when the state is OWN_x and m_waitrequest=0; it SHALL be 1 in every other cycle.
REQ-027 Latency: a request first seen in IDLE at cycle n SHALL appear on m_* at cycle n+1; with a zero-wait agent, the host SHALL see waitrequest=0 at n+1.
REQ-028 i_readdata and d_readdata SHALL both pass m_readdata through combinationally.
REQ-029 If the owner drops its request while in OWN_x, m_read and m_write SHALL drop in the same cycle and the FSM SHALL return to IDLE at the next edge (abort).
REQ-030 If d_read and d_write are high together, the arbiter SHALL forward the write and force m_read to 0.
REQ-031 conflict_count SHALL increment in every IDLE cycle in which both hosts request, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-032 When rst=0 at a clock edge, the FSM SHALL go to IDLE, last_owner SHALL go to INSTR (so the first tie goes to data), and conflict_count SHALL go to 0.
REQ-033 Reset mid-transaction SHALL abort it: m_read=m_write=0 and both waitrequests=1 from the cycle after that edge.

Structure
REQ-034 The shared package Types SHALL hold owner_t (OWNER_INSTR, OWNER_DATA) and arb_state_t (ARB_IDLE, ARB_OWN_I, ARB_OWN_D).
REQ-035 The block SHALL be a single module with no sub-module; the FSM, last_owner flop, conflict counter and output muxes are all local.

Verification
REQ-036 Only i_read=1 at i_address=0x100, with a zero-wait agent returning 0xDEADBEEF: m_read=1 with m_address=0x100 at cycle n+1, i_waitrequest=0 and i_readdata=0xDEADBEEF at n+1, then IDLE at n+2.
REQ-037 i_read and d_write both asserted from reset: data granted first, then instruction; conflict_count=1 after the first tie.
REQ-038 d_write of 0x12345678 with byteenable 0xF while the agent holds m_waitrequest=1 for 3 cycles: m_* held stable for 4 cycles and d_waitrequest=1 for the first 3 of them.
REQ-039 Both hosts requesting continuously for 8 transactions: grants strictly alternate (data, instr, ...) and conflict_count=8.
REQ-040 Assert rst=0 in OWN_D with the agent stalled: IDLE next cycle, m_write=0, and conflict_count=0.
REQ-041 d_read and d_write high together: m_write=1 and m_read=0.
